fifo_wr_arbiter: RTL and testbench

Round-robin write-side arbiter that shares one `fifo` instance among `NREQ` producers. Each producer offers words through a valid/ready handshake. The arbiter grants one owner at a time for a burst of up to `BURST` words and drives the FIFO's `wr_en`/`din`, stalling on `full`. It sits directly in front of the FIFO's write port. The FIFO read side is untouched.

---
 rtl/fifo_wr_arbiter_pkg.sv | 17 +
 rtl/fifo_wr_arbiter_if.sv | 22 ++
 rtl/fifo_wr_arbiter_rr_pick.sv | 27 ++
 rtl/fifo_wr_arbiter.sv | 106 ++++++++++
 tb/tb_fifo_wr_arbiter.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and width helpers for the round-robin FIFO write arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    localparam int NREQ_DEF = 4;
    localparam int IDX_W    = (NREQ_DEF > 1) ? $clog2(NREQ_DEF) : 1;

    // Index width that stays at least one bit for degenerate sizes.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester handshake plus FIFO write port, shared by arbiter and its environment.
interface fifo_wr_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  fifo_full;
    logic                  fifo_wr_en;
    logic [WIDTH-1:0]      fifo_din;

    modport master (
        input  req_valid, req_data, fifo_full,
        output req_ready, fifo_wr_en, fifo_din
    );

    modport slave (
        output req_valid, req_data, fifo_full,
        input  req_ready, fifo_wr_en, fifo_din
    );
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after the pointer.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]              i_req,
    input  logic [idx_width(NREQ)-1:0]   i_ptr,
    output logic [NREQ-1:0]              o_grant,
    output logic [idx_width(NREQ)-1:0]   o_idx
);
    localparam int IW = idx_width(NREQ);

    // Scan from farthest to nearest so the slot closest to the pointer wins last.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (i_req[(int'(i_ptr) + k) % NREQ]) begin
                o_grant = '0;
                o_grant[(int'(i_ptr) + k) % NREQ] = 1'b1;
                o_idx   = IW'((int'(i_ptr) + k) % NREQ);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one FIFO write port among NREQ producers.
//   state | meaning
//   IDLE  | no grant; arbitrate among valid requesters for next cycle
//   BUSY  | owner holds the port for up to BURST words, stalls on full
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int BURST = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    fifo_wr_arbiter_if.master             bus,
    output logic [idx_width(NREQ)-1:0]    owner,
    output logic                          busy
);
    localparam int IW = idx_width(NREQ);
    localparam int BW = idx_width(BURST);

    arb_state_e      r_state, w_state_nxt;
    logic [IW-1:0]   r_owner, w_owner_nxt;
    logic [IW-1:0]   r_ptr, w_ptr_nxt;
    logic [BW-1:0]   r_beats, w_beats_nxt;

    logic [NREQ-1:0] w_pick_grant;
    logic [IW-1:0]   w_pick_idx;
    logic            w_any_req;
    logic            w_busy;
    logic            w_own_valid;
    logic [WIDTH-1:0] w_own_data;
    logic            w_xfer;
    logic            w_end;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .i_req   (bus.req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_pick_grant),
        .o_idx   (w_pick_idx)
    );

    assign w_any_req   = |w_pick_grant;
    assign w_busy      = (r_state == BUSY);
    assign w_own_valid = bus.req_valid[r_owner];
    assign w_own_data  = bus.req_data[int'(r_owner)*WIDTH +: WIDTH];
    assign w_xfer      = w_busy && w_own_valid && !bus.fifo_full;
    // Dropping valid ends the grant even while stalled on full.
    assign w_end       = w_busy && (!w_own_valid || (w_xfer && (r_beats == BW'(BURST - 1))));

    always_comb begin
        w_state_nxt    = r_state;
        w_owner_nxt    = r_owner;
        w_ptr_nxt      = r_ptr;
        w_beats_nxt    = r_beats;
        bus.req_ready  = '0;
        bus.fifo_wr_en = 1'b0;
        bus.fifo_din   = '0;

        if (w_busy && !bus.fifo_full) begin
            bus.req_ready[r_owner] = 1'b1;
        end
        if (w_xfer) begin
            bus.fifo_wr_en = 1'b1;
            bus.fifo_din   = w_own_data;
        end

        case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = BUSY;
                    w_owner_nxt = w_pick_idx;
                end
            end
            BUSY: begin
                if (w_end) begin
                    w_state_nxt = IDLE;
                    w_ptr_nxt   = (r_owner == IW'(NREQ - 1)) ? '0 : r_owner + 1'b1;
                    w_beats_nxt = '0;
                end else if (w_xfer) begin
                    w_beats_nxt = r_beats + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_owner <= '0;
            r_ptr   <= '0;
            r_beats <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_ptr   <= w_ptr_nxt;
            r_beats <= w_beats_nxt;
        end
    end

    assign owner = r_owner;
    assign busy  = w_busy;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a cycle-level reference model.
module tb_fifo_wr_arbiter;
    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int BURST = 4;
    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] owner;
    logic       busy;

    fifo_wr_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

    fifo_wr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .BURST(BURST)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .owner (owner),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    // Stimulus: per-requester word queues, offered while enabled
    logic [7:0] pend [NREQ][$];
    bit         en [NREQ];
    bit         force_full;
    bit         rd_en;

    // FIFO model and scoreboard of words the reference expects to be written
    logic [7:0] fifo_q [$];
    logic [7:0] exp_out [$];

    // Reference model: grant holder, priority start and words written this grant
    bit m_busy;
    int m_owner, m_ptr, m_cnt;

    // Observed DUT history
    int         dut_grants [$];
    logic [7:0] dut_words [$];
    bit         dut_prev_busy;
    int         n_wr;

    int checks = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_busy = 0; m_owner = 0; m_ptr = 0; m_cnt = 0;
        dut_prev_busy = 0;
        dut_grants.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.req_valid = '1;
        bus.req_data  = '1;
        bus.fifo_full = 1'b0;
        #1;
        check_val("rst_ready", bus.req_ready, 0);
        check_val("rst_wr_en", bus.fifo_wr_en, 0);
        check_val("rst_busy",  busy, 0);
        check_val("rst_owner", owner, 0);
        for (int i = 0; i < NREQ; i++) begin
            pend[i].delete();
            en[i] = 0;
        end
        force_full = 0;
        rd_en = 1;
        fifo_q.delete();
        exp_out.delete();
        dut_words.delete();
        n_wr = 0;
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        bus.req_valid = '0;
    endtask

    // One clock: drive inputs, compare outputs with the model, then advance model and FIFO.
    task automatic cycle();
        logic [NREQ-1:0]       v;
        logic [NREQ*WIDTH-1:0] d;
        bit                    full, wr;
        logic [7:0]            got, exp;
        @(negedge clk);
        full = force_full || (fifo_q.size() >= DEPTH);
        for (int i = 0; i < NREQ; i++) begin
            v[i] = en[i] && (pend[i].size() > 0);
            d[i*WIDTH +: WIDTH] = v[i] ? pend[i][0] : 8'($urandom);
        end
        bus.req_valid = v;
        bus.req_data  = d;
        bus.fifo_full = full;
        #1;
        wr = m_busy && v[m_owner] && !full;
        check_val("ready", bus.req_ready, (m_busy && !full) ? (32'd1 << m_owner) : 32'd0);
        check_val("wr_en", bus.fifo_wr_en, wr);
        check_val("din",   bus.fifo_din, wr ? pend[m_owner][0] : 8'd0);
        check_val("busy",  busy, m_busy);
        if (m_busy) check_val("owner", owner, m_owner);

        if (busy && !dut_prev_busy) dut_grants.push_back(int'(owner));
        dut_prev_busy = busy;

        if (rd_en && fifo_q.size() > 0) begin
            got = fifo_q.pop_front();
            exp = (exp_out.size() > 0) ? exp_out.pop_front() : 8'hxx;
            check_val("fifo_order", got, exp);
        end
        if (bus.fifo_wr_en) begin
            n_wr++;
            fifo_q.push_back(bus.fifo_din);
            dut_words.push_back(bus.fifo_din);
        end

        if (!m_busy) begin
            for (int k = 0; k < NREQ; k++) begin
                int j;
                j = (m_ptr + k) % NREQ;
                if (v[j]) begin
                    m_busy = 1; m_owner = j; m_cnt = 0;
                    break;
                end
            end
        end else begin
            int o;
            o = m_owner;
            if (wr) begin
                exp_out.push_back(pend[o].pop_front());
                m_cnt++;
            end
            if ((wr && m_cnt == BURST) || !v[o]) begin
                m_busy = 0;
                m_ptr  = (o + 1) % NREQ;
            end
        end
    endtask

    task automatic run(input int n);
        for (int c = 0; c < n; c++) cycle();
    endtask

    initial begin
        int cnt, snap;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.fifo_full = 1'b0;
        rd_en = 1;

        // Single requester: two bursts 4+2 with an IDLE bubble between
        do_reset();
        for (int k = 0; k < 6; k++) pend[1].push_back(8'h10 + 8'(k));
        en[1] = 1;
        run(14);
        check_val("single_ngrants", dut_grants.size(), 2);
        for (int k = 0; k < 2; k++)
            check_val("single_owner", (k < dut_grants.size()) ? dut_grants[k] : -1, 1);
        for (int k = 0; k < 6; k++)
            check_val("single_word", (k < dut_words.size()) ? dut_words[k] : 8'hxx, 8'h10 + 8'(k));

        // Rotation: all requesters continuously valid
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            for (int k = 0; k < 8; k++) pend[i].push_back(8'((i << 4) | k));
            en[i] = 1;
        end
        run(50);
        for (int k = 0; k < 8; k++)
            check_val("rot_owner", (k < dut_grants.size()) ? dut_grants[k] : -1, k % NREQ);
        check_val("rot_nwr", n_wr, 32);
        for (int i = 0; i < NREQ; i++) check_val("rot_drained", pend[i].size(), 0);

        // Backpressure: full for 3 cycles after two beats of req0
        do_reset();
        for (int k = 0; k < 4; k++) pend[0].push_back(8'hA0 + 8'(k));
        en[0] = 1;
        rd_en = 0;
        run(3);
        check_val("bp_pre_nwr", n_wr, 2);
        force_full = 1;
        snap = n_wr;
        run(3);
        check_val("bp_stall_nwr", n_wr - snap, 0);
        force_full = 0;
        run(4);
        check_val("bp_total_nwr", n_wr, 4);
        check_val("bp_ngrants", dut_grants.size(), 1);

        // Early release: req2 drops after two beats, then 3 before 0
        do_reset();
        for (int i = 0; i < NREQ; i++)
            for (int k = 0; k < 4; k++) pend[i].push_back(8'((i << 4) | k));
        en[2] = 1;
        run(3);
        en[2] = 0; en[3] = 1; en[0] = 1;
        run(14);
        cnt = 0;
        foreach (dut_words[k]) if (dut_words[k][7:4] == 4'h2) cnt++;
        check_val("early_req2_words", cnt, 2);
        for (int k = 0; k < 3; k++)
            check_val("early_owner", (k < dut_grants.size()) ? dut_grants[k] : -1, (k == 0) ? 2 : (k == 1) ? 3 : 0);

        // Wrap priority: pointer at 2, req1 and req3 race, 3 wins then 1
        do_reset();
        pend[1].push_back(8'h11);
        en[1] = 1;
        run(3);
        pend[1].push_back(8'h12);
        pend[3].push_back(8'h31);
        en[3] = 1;
        run(8);
        for (int k = 0; k < 3; k++)
            check_val("wrap_owner", (k < dut_grants.size()) ? dut_grants[k] : -1, (k == 1) ? 3 : 1);

        // Async reset during beat 1 of req3
        do_reset();
        for (int k = 0; k < 4; k++) pend[3].push_back(8'h30 + 8'(k));
        en[3] = 1;
        run(2);
        @(negedge clk);
        bus.req_valid = 4'b1000;
        bus.req_data  = {pend[3][0], 24'h0};
        bus.fifo_full = 1'b0;
        #1;
        check_val("ar_pre_wr_en", bus.fifo_wr_en, 1);
        #2 rst_n = 1'b0;
        #1;
        check_val("ar_wr_en", bus.fifo_wr_en, 0);
        check_val("ar_ready", bus.req_ready, 0);
        check_val("ar_busy",  busy, 0);
        check_val("ar_din",   bus.fifo_din, 0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        bus.req_valid = '0;
        pend[0].push_back(8'h05);
        en[0] = 1;
        run(8);
        check_val("ar_first_owner", (dut_grants.size() > 0) ? dut_grants[0] : -1, 0);
        check_val("ar_req3_words", pend[3].size(), 0);

        // Random traffic with reads stalling and spurious full
        do_reset();
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (pend[i].size() < 6 && $urandom_range(3) == 0) pend[i].push_back(8'($urandom));
                en[i] = ($urandom_range(15) != 0);
            end
            rd_en = ($urandom_range(1) == 0);
            force_full = ($urandom_range(7) == 0);
            cycle();
        end
        for (int i = 0; i < NREQ; i++) en[i] = 1;
        rd_en = 1;
        force_full = 0;
        for (int c = 0; c < 400; c++) begin
            if (pend[0].size() + pend[1].size() + pend[2].size() + pend[3].size()
                + fifo_q.size() == 0) break;
            cycle();
        end
        check_val("rand_pending", pend[0].size() + pend[1].size() + pend[2].size() + pend[3].size(), 0);
        check_val("rand_fifo_empty", fifo_q.size(), 0);
        check_val("rand_exp_empty", exp_out.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
